serial_comparator_ctrl: RTL and testbench

Sequencer that compares two WIDTH-bit unsigned operands with a single 1-bit cascade comparator cell, one bit per clock, MSB first. It loads both operands on a start request and walks the bit index downward. It stops early at the first differing bit and reports greater, equal or less with a one-cycle done pulse. This block replaces a WIDTH-deep chain of comparator cells with one shared cell plus a controller.

---
 rtl/serial_comparator_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_comparator_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_comparator_ctrl
//  Description : Bit-serial magnitude comparator. A single 1-bit cascade
//                cell is walked over two captured operands, MSB first,
//                stopping at the first differing bit and reporting
//                greater / equal / less with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_comparator_ctrl #(
    parameter int WIDTH = 8,   // operand width in bits, >= 2
    parameter int IDX_W = 3    // bit-index width, 2**IDX_W >= WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             aGb,
    output logic             aEb,
    output logic             aLb
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] C_IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               g_q, g_d;
    logic               e_q, e_d;
    logic               l_q, l_d;
    logic               agb_q, agb_d;
    logic               aeb_q, aeb_d;
    logic               alb_q, alb_d;

    logic               w_ai;
    logic               w_bi;
    logic               w_cell_g;
    logic               w_cell_e;
    logic               w_cell_l;

    // Shared comparator cell applied to the currently selected bit pair.
    always_comb begin
        w_ai     = a_q[index_q];
        w_bi     = b_q[index_q];
        w_cell_l = l_q | (~w_ai &  w_bi & e_q);
        w_cell_e = ~(w_ai ^ w_bi) & e_q;
        w_cell_g = g_q | ( w_ai & ~w_bi & e_q);
    end

    // Next-state and datapath updates for the IDLE/COMPARE/DONE sequencer.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        agb_d   = agb_q;
        aeb_d   = aeb_q;
        alb_d   = alb_q;

        case (state_q)
            ST_IDLE: begin
                // Operands are only captured here, so later input changes
                // and start requests while busy cannot disturb a comparison.
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    index_d = C_IDX_MSB;
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    state_d = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                g_d = w_cell_g;
                e_d = w_cell_e;
                l_d = w_cell_l;
                // Once a difference is seen the outcome is fixed, so stop
                // early; bit 0 always terminates so the index never wraps.
                if (!w_cell_e || (index_q == '0)) begin
                    agb_d   = w_cell_g;
                    aeb_d   = w_cell_e;
                    alb_d   = w_cell_l;
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q - C_IDX_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b1;
            l_q     <= 1'b0;
            agb_q   <= 1'b0;
            aeb_q   <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            agb_q   <= agb_d;
            aeb_q   <= aeb_d;
            alb_q   <= alb_d;
        end
    end

    assign busy = (state_q == ST_COMPARE) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign aGb  = agb_q;
    assign aEb  = aeb_q;
    assign aLb  = alb_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_comparator_ctrl
//  Description : Self-checking bench for serial_comparator_ctrl against a
//                behavioural model of the comparison result and latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_comparator_ctrl;

    localparam int W  = 8;
    localparam int IW = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         aGb;
    logic         aEb;
    logic         aLb;

    int total = 0;
    int bad   = 0;

    serial_comparator_ctrl #(
        .WIDTH (W),
        .IDX_W (IW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .aGb   (aGb),
        .aEb   (aEb),
        .aLb   (aLb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: done arrives in cycle W-k+1 for highest differing bit k,
    // or W+1 when the operands are equal.
    function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] diff;
        diff = a ^ b;
        for (int k = W - 1; k >= 0; k--) begin
            if (diff[k]) return W - k + 1;
        end
        return W + 1;
    endfunction

    function automatic logic [2:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b);
        return {(a > b), (a == b), (a < b)};
    endfunction

    // Launch one comparison from an IDLE negedge and wait for done.
    // lat is the cycle in which done was seen (0 if it never came).
    // Inputs are scrambled after capture to show they are not re-sampled.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int busy_cnt);
        start    = 1'b1;
        a_in     = a;
        b_in     = b;
        lat      = 0;
        busy_cnt = 0;
        for (int c = 1; c <= W + 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, aGb, aEb, aLb} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_state: got busy/done/gel=%b want 00000",
                     {busy, done, aGb, aEb, aLb});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: got busy/done=%b want 00", {busy, done});
        end
    endtask

    // Directed comparison with latency, busy duration and result checks.
    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, bc;
        run_cmp(a, b, lat, bc);
        total++;
        if (lat !== model_latency(a, b)) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, model_latency(a, b));
        end
        total++;
        if (bc !== model_latency(a, b)) begin
            bad++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, model_latency(a, b));
        end
        total++;
        if ({aGb, aEb, aLb} !== model_result(a, b)) begin
            bad++;
            $display("FAIL %s_result: got gel=%b want %b", name, {aGb, aEb, aLb}, model_result(a, b));
        end
        @(negedge clk);
        total++;
        if ({busy, done, aGb, aEb, aLb} !== {2'b00, model_result(a, b)}) begin
            bad++;
            $display("FAIL %s_after_done: got busy/done/gel=%b want %b", name,
                     {busy, done, aGb, aEb, aLb}, {2'b00, model_result(a, b)});
        end
    endtask

    // Start and operand changes during COMPARE/DONE must be ignored.
    task automatic test_ignore_start();
        int lat;
        lat   = 0;
        start = 1'b1;
        a_in  = 8'h50;
        b_in  = 8'h10;
        for (int c = 1; c <= W + 6; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                start = 1'b1;
                a_in  = 8'h00;
                b_in  = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (lat !== model_latency(8'h50, 8'h10)) begin
            bad++;
            $display("FAIL ignore_latency: got %0d want %0d", lat, model_latency(8'h50, 8'h10));
        end
        total++;
        if ({aGb, aEb, aLb} !== model_result(8'h50, 8'h10)) begin
            bad++;
            $display("FAIL ignore_result: got gel=%b want %b", {aGb, aEb, aLb}, model_result(8'h50, 8'h10));
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({busy, done} !== 2'b00) begin
                bad++;
                $display("FAIL ignore_no_restart: got busy/done=%b want 00 (cycle %0d)", {busy, done}, c);
            end
        end
    endtask

    // Start held high: one comparison per IDLE slot, done every 3 cycles.
    task automatic test_back_to_back();
        int n_done;
        n_done = 0;
        start  = 1'b1;
        a_in   = 8'hFF;
        b_in   = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                total++;
                if ((c % 3) != 2 || {aGb, aEb, aLb} !== 3'b100) begin
                    bad++;
                    $display("FAIL b2b_pulse: got done in cycle %0d gel=%b want cycle%%3==2 gel=100",
                             c, {aGb, aEb, aLb});
                end
            end
        end
        start = 1'b0;
        total++;
        if (n_done !== 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d done pulses want 4", n_done);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop: got busy=%b want 0", busy);
        end
    endtask

    // Reset mid-comparison aborts with no done; rst beats start.
    task automatic test_rst_abort();
        int lat, bc, spurious;
        spurious = 0;
        start = 1'b1;
        a_in  = 8'h00;
        b_in  = 8'h00;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) spurious++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, aGb, aEb, aLb} !== 5'b00000) begin
            bad++;
            $display("FAIL rst_abort_state: got busy/done/gel=%b want 00000", {busy, done, aGb, aEb, aLb});
        end
        rst = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("FAIL rst_abort_no_done: got %0d busy/done cycles want 0", spurious);
        end
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'h01;
        b_in  = 8'h02;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_beats_start: got busy=%b want 0", busy);
        end
        run_cmp(8'h01, 8'h02, lat, bc);
        total++;
        if (lat !== model_latency(8'h01, 8'h02) || {aGb, aEb, aLb} !== 3'b001) begin
            bad++;
            $display("FAIL rst_then_cmp: got lat=%0d gel=%b want lat=%0d gel=001",
                     lat, {aGb, aEb, aLb}, model_latency(8'h01, 8'h02));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int lat, bc, mode;
        for (int i = 0; i < 60; i++) begin
            mode = int'($urandom_range(0, 2));
            a    = W'($urandom);
            b    = W'($urandom);
            if (mode == 1) b = a;
            if (mode == 2) b = a ^ (W'(1) << $urandom_range(0, W - 1));
            run_cmp(a, b, lat, bc);
            total++;
            if (lat !== model_latency(a, b) || {aGb, aEb, aLb} !== model_result(a, b)) begin
                bad++;
                $display("FAIL random_cmp: a=%h b=%h got lat=%0d gel=%b want lat=%0d gel=%b",
                         a, b, lat, {aGb, aEb, aLb}, model_latency(a, b), model_result(a, b));
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL random_pulse_width: a=%h b=%h got done=%b want 0", a, b, done);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed("equal_a5", 8'hA5, 8'hA5);
        test_directed("msb_diff", 8'h80, 8'h7F);
        test_directed("lsb_diff", 8'h3C, 8'h3D);
        test_ignore_start();
        test_back_to_back();
        test_rst_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
